// File: rtl/position_tracker_xy.sv
// Two-axis object position tracker: steps X/Y on each movement tick and
// sequences the draw controller through an erase-old / draw-new handshake.
module position_tracker_xy #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 156,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 116,
    parameter int STEP_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              move,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    input  logic              wrap_x,
    input  logic              wrap_y,
    input  logic              pause,
    input  logic              load,
    input  logic [X_W-1:0]    x_load,
    input  logic [Y_W-1:0]    y_load,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              erase_req,
    output logic              draw_req,
    input  logic              done,
    output logic              dir_x,
    output logic              dir_y,
    output logic              bounce,
    output logic              overrun,
    output logic              busy
);

    // One extra bit above the widest coordinate keeps p + s from overflowing.
    localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [AW-1:0] X_MIN_A = AW'(X_MIN);
    localparam logic [AW-1:0] X_MAX_A = AW'(X_MAX);
    localparam logic [AW-1:0] Y_MIN_A = AW'(Y_MIN);
    localparam logic [AW-1:0] Y_MAX_A = AW'(Y_MAX);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW-1:0] ZERO_A  = AW'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        UPDATE = 2'd2,
        DRAW   = 2'd3
    } state_t;

    // Returns {bounce, new_dir, new_pos} for one axis.
    function automatic logic [AW+1:0] step_axis(
        input logic [AW-1:0] p,
        input logic [AW-1:0] s,
        input logic [AW-1:0] mn,
        input logic [AW-1:0] mx,
        input logic          wrap,
        input logic          dir
    );
        logic [AW-1:0] np;
        logic          nd;
        logic          b;
        np = p;
        nd = dir;
        b  = 1'b0;
        if (s == ZERO_A) begin
            np = p;
        end else if (!wrap && !dir) begin
            if (p + s >= mx) begin
                np = mx; nd = 1'b1; b = 1'b1;
            end else begin
                np = p + s;
            end
        end else if (!wrap && dir) begin
            if (p <= mn + s) begin
                np = mn; nd = 1'b0; b = 1'b1;
            end else begin
                np = p - s;
            end
        end else if (!dir) begin
            if (p + s > mx) begin
                np = mn + (p + s - mx - ONE_A); b = 1'b1;
            end else begin
                np = p + s;
            end
        end else begin
            if (p < mn + s) begin
                np = mx - (mn + s - p - ONE_A); b = 1'b1;
            end else begin
                np = p - s;
            end
        end
        return {b, nd, np};
    endfunction

    function automatic logic [AW-1:0] clamp(
        input logic [AW-1:0] v,
        input logic [AW-1:0] mn,
        input logic [AW-1:0] mx
    );
        logic [AW-1:0] r;
        if (v <= mn) begin
            r = mn;
        end else if (v >= mx) begin
            r = mx;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [X_W-1:0] r_pos_x, w_pos_x_nxt;
    logic [Y_W-1:0] r_pos_y, w_pos_y_nxt;
    logic           r_dir_x, w_dir_x_nxt;
    logic           r_dir_y, w_dir_y_nxt;
    logic           r_pending, w_pending_nxt;
    logic           r_bounce, w_bounce_nxt;
    logic           r_overrun, w_overrun_nxt;
    logic           r_erase_req, r_draw_req, r_busy;
    logic [AW+1:0]  w_x_res, w_y_res;
    logic [AW-1:0]  w_x_clamp, w_y_clamp;

    assign w_x_res   = step_axis(AW'(r_pos_x), AW'(step_x), X_MIN_A, X_MAX_A, wrap_x, r_dir_x);
    assign w_y_res   = step_axis(AW'(r_pos_y), AW'(step_y), Y_MIN_A, Y_MAX_A, wrap_y, r_dir_y);
    assign w_x_clamp = clamp(AW'(x_load), X_MIN_A, X_MAX_A);
    assign w_y_clamp = clamp(AW'(y_load), Y_MIN_A, Y_MAX_A);

    // Next-state, position update and tick bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_pos_x_nxt   = r_pos_x;
        w_pos_y_nxt   = r_pos_y;
        w_dir_x_nxt   = r_dir_x;
        w_dir_y_nxt   = r_dir_y;
        w_pending_nxt = r_pending;
        w_bounce_nxt  = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_pos_x_nxt = X_W'(w_x_clamp);
                    w_pos_y_nxt = Y_W'(w_y_clamp);
                    if (move && !pause) begin
                        w_pending_nxt = 1'b1;
                    end else begin
                        w_pending_nxt = r_pending;
                    end
                end else if (!pause && (move || r_pending)) begin
                    w_state_nxt   = ERASE;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ERASE: begin
                if (done) begin
                    w_state_nxt = UPDATE;
                end else begin
                    w_state_nxt = ERASE;
                end
            end
            UPDATE: begin
                w_pos_x_nxt  = X_W'(w_x_res);
                w_pos_y_nxt  = Y_W'(w_y_res);
                w_dir_x_nxt  = w_x_res[AW];
                w_dir_y_nxt  = w_y_res[AW];
                w_bounce_nxt = w_x_res[AW+1] | w_y_res[AW+1];
                w_state_nxt  = DRAW;
            end
            DRAW: begin
                if (done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAW;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Only one tick can be queued while the handshake is in flight.
        if (r_state != IDLE && move) begin
            if (r_pending) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_pending_nxt = 1'b1;
            end
        end else begin
            w_overrun_nxt = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position, direction and registered handshake/pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pos_x     <= X_W'(X_MIN);
            r_pos_y     <= Y_W'(Y_MIN);
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_pending   <= 1'b0;
            r_bounce    <= 1'b0;
            r_overrun   <= 1'b0;
            r_erase_req <= 1'b0;
            r_draw_req  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pos_x     <= w_pos_x_nxt;
            r_pos_y     <= w_pos_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_pending   <= w_pending_nxt;
            r_bounce    <= w_bounce_nxt;
            r_overrun   <= w_overrun_nxt;
            r_erase_req <= (w_state_nxt == ERASE);
            r_draw_req  <= (w_state_nxt == DRAW);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign x_out     = r_pos_x;
    assign y_out     = r_pos_y;
    assign dir_x     = r_dir_x;
    assign dir_y     = r_dir_y;
    assign bounce    = r_bounce;
    assign overrun   = r_overrun;
    assign erase_req = r_erase_req;
    assign draw_req  = r_draw_req;
    assign busy      = r_busy;

endmodule
